// File: rtl/gear_selector_fsm_pkg.sv
// Shared types and helpers for the gear selector: mode encoding, gear width
// calculation and lever request priority encoding.
package gear_pkg;

  typedef enum logic [1:0] {
    MODE_P = 2'b00,
    MODE_N = 2'b01,
    MODE_R = 2'b10,
    MODE_D = 2'b11
  } mode_e;

  typedef struct packed {
    logic  valid;
    mode_e mode;
  } req_t;

  // Width needed to hold gear numbers 0..num_gears
  function automatic int unsigned gear_width(input int unsigned num_gears);
    return $clog2(num_gears + 1);
  endfunction

  // Lever priority P > N > R > D; valid low means no request this cycle
  function automatic req_t encode_req(input logic sel_p, input logic sel_n,
                                      input logic sel_r, input logic sel_d);
    req_t r;
    r.valid = sel_p | sel_n | sel_r | sel_d;
    if (sel_p)      r.mode = MODE_P;
    else if (sel_n) r.mode = MODE_N;
    else if (sel_r) r.mode = MODE_R;
    else            r.mode = MODE_D;
    return r;
  endfunction

endpackage

// File: rtl/gear_selector_fsm_if.sv
// Lever/speed inputs and mode/gear indications of the gear selector.
// GEAR_SELECTOR_KICKDOWN_EN adds the kickdown request line.
interface gear_selector_fsm_if #(
  parameter int unsigned NUM_GEARS = 6,
  parameter int unsigned SPEED_W   = 8
);
  import gear_pkg::*;

  localparam int unsigned GEAR_W = gear_width(NUM_GEARS);

  logic                 sel_p;
  logic                 sel_n;
  logic                 sel_r;
  logic                 sel_d;
  logic [SPEED_W-1:0]   speed;
`ifdef GEAR_SELECTOR_KICKDOWN_EN
  logic                 kickdown;
`endif
  logic [1:0]           mode_o;
  logic                 p_o;
  logic                 n_o;
  logic                 r_o;
  logic [GEAR_W-1:0]    gear_o;
  logic [NUM_GEARS-1:0] gear_oh_o;
  logic                 shift_o;
  logic                 reject_o;

`ifdef GEAR_SELECTOR_KICKDOWN_EN
  modport master (output sel_p, sel_n, sel_r, sel_d, speed, kickdown,
                  input  mode_o, p_o, n_o, r_o, gear_o, gear_oh_o, shift_o, reject_o);
  modport slave  (input  sel_p, sel_n, sel_r, sel_d, speed, kickdown,
                  output mode_o, p_o, n_o, r_o, gear_o, gear_oh_o, shift_o, reject_o);
`else
  modport master (output sel_p, sel_n, sel_r, sel_d, speed,
                  input  mode_o, p_o, n_o, r_o, gear_o, gear_oh_o, shift_o, reject_o);
  modport slave  (input  sel_p, sel_n, sel_r, sel_d, speed,
                  output mode_o, p_o, n_o, r_o, gear_o, gear_oh_o, shift_o, reject_o);
`endif

endinterface

// File: rtl/gear_selector_fsm_shift_dwell_timer.sv
// Minimum-dwell timer between gear shifts: load, saturating decrement, clear.
module shift_dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  logic dec,
  output logic zero_c
);

  localparam int unsigned   CW       = $clog2(DWELL_CYCLES) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Clear beats load; decrement stops at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     cnt_q <= '0;
    else if (clear)                cnt_q <= '0;
    else if (load)                 cnt_q <= LOAD_VAL;
    else if (dec && cnt_q != '0)   cnt_q <= cnt_q - CW'(1);
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/gear_selector_fsm.sv
// P/N/R/D selector with speed interlock and dwell-limited automatic shifting
// over NUM_GEARS forward gears. Optional macro GEAR_SELECTOR_KICKDOWN_EN
// adds a forced one-gear kickdown downshift.
module gear_selector_fsm
  import gear_pkg::*;
#(
  parameter int unsigned NUM_GEARS    = 6,
  parameter int unsigned SPEED_W      = 8,
  parameter int unsigned SHIFT_STEP   = 20,
  parameter int unsigned HYST         = 4,
  parameter int unsigned DWELL_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  gear_selector_fsm_if.slave bus
);

  localparam int unsigned       GEAR_W   = gear_width(NUM_GEARS);
  localparam int unsigned       TW       = SPEED_W + GEAR_W + 1;
  localparam logic [GEAR_W-1:0] GEAR_ONE = GEAR_W'(1);
  localparam logic [GEAR_W-1:0] GEAR_MAX = GEAR_W'(NUM_GEARS);

  mode_e                mode_q, mode_d;
  logic [GEAR_W-1:0]    gear_q, gear_d;
  logic [NUM_GEARS-1:0] gear_oh_d;
  logic                 shift_d, reject_d;
  logic                 tmr_load, tmr_clear, tmr_zero_c;
  logic                 grant_c, up_c, down_c, kd_fire_c;
  logic [TW-1:0]        speed_ext_c, up_thr_c, down_thr_c;
  req_t                 req_c;

  shift_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .clear  (tmr_clear),
    .dec    (mode_q == MODE_D),
    .zero_c (tmr_zero_c)
  );

  assign req_c = encode_req(bus.sel_p, bus.sel_n, bus.sel_r, bus.sel_d);

  // Interlock: N always; P/R only at standstill; D from R only at standstill
  always_comb begin
    case (req_c.mode)
      MODE_N:  grant_c = 1'b1;
      MODE_D:  grant_c = (mode_q != MODE_R) || (bus.speed == '0);
      default: grant_c = (bus.speed == '0);
    endcase
  end

  // Shift thresholds at widened precision so nothing truncates
  always_comb begin
    speed_ext_c = TW'(bus.speed);
    up_thr_c    = TW'(gear_q) * TW'(SHIFT_STEP);
    down_thr_c  = TW'(gear_q - GEAR_ONE) * TW'(SHIFT_STEP);
    up_c        = (gear_q < GEAR_MAX) && (speed_ext_c >= up_thr_c);
    down_c      = (gear_q > GEAR_ONE) && ((speed_ext_c + TW'(HYST)) < down_thr_c);
  end

`ifdef GEAR_SELECTOR_KICKDOWN_EN
  logic kd_lock_q;

  // One kickdown per dwell window; firing ignores the dwell counter itself
  assign kd_fire_c = bus.kickdown && (mode_q == MODE_D) && (gear_q > GEAR_ONE) &&
                     (!kd_lock_q || tmr_zero_c);

  // Lock further kickdowns until the dwell started by this one expires
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  kd_lock_q <= 1'b0;
    else if (mode_d != MODE_D)  kd_lock_q <= 1'b0;
    else if (kd_fire_c)         kd_lock_q <= 1'b1;
    else if (tmr_zero_c)        kd_lock_q <= 1'b0;
  end
`else
  assign kd_fire_c = 1'b0;
`endif

  // Next mode/gear: a granted mode change pre-empts any shift evaluation
  always_comb begin
    mode_d    = mode_q;
    gear_d    = gear_q;
    shift_d   = 1'b0;
    reject_d  = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    if (req_c.valid && (req_c.mode != mode_q) && grant_c) begin
      mode_d = req_c.mode;
      if (req_c.mode == MODE_D) begin
        gear_d   = GEAR_ONE;
        tmr_load = 1'b1;
      end else begin
        gear_d    = '0;
        tmr_clear = 1'b1;
      end
    end else begin
      reject_d = req_c.valid && (req_c.mode != mode_q);
      if (mode_q == MODE_D) begin
        if (kd_fire_c || (tmr_zero_c && down_c)) begin
          gear_d   = gear_q - GEAR_ONE;
          shift_d  = 1'b1;
          tmr_load = 1'b1;
        end else if (tmr_zero_c && up_c) begin
          gear_d   = gear_q + GEAR_ONE;
          shift_d  = 1'b1;
          tmr_load = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_GEARS; i++) begin
      gear_oh_d[i] = (gear_d == GEAR_W'(i + 1));
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= MODE_P;
      gear_q        <= '0;
      bus.mode_o    <= MODE_P;
      bus.p_o       <= 1'b1;
      bus.n_o       <= 1'b0;
      bus.r_o       <= 1'b0;
      bus.gear_o    <= '0;
      bus.gear_oh_o <= '0;
      bus.shift_o   <= 1'b0;
      bus.reject_o  <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      gear_q        <= gear_d;
      bus.mode_o    <= mode_d;
      bus.p_o       <= (mode_d == MODE_P);
      bus.n_o       <= (mode_d == MODE_N);
      bus.r_o       <= (mode_d == MODE_R);
      bus.gear_o    <= gear_d;
      bus.gear_oh_o <= gear_oh_d;
      bus.shift_o   <= shift_d;
      bus.reject_o  <= reject_d;
    end
  end

endmodule

// File: tb/tb_gear_selector_fsm.sv
// Scoreboard bench for gear_selector_fsm: directed lever/speed scenarios then
// randomized traffic against a cycle-count reference model.
module tb_gear_selector_fsm;

  localparam int NG    = 4;
  localparam int SW    = 8;
  localparam int STEP  = 20;
  localparam int HY    = 4;
  localparam int DWELL = 16;

  typedef struct {
    int mode;
    int p;
    int n;
    int r;
    int gear;
    int oh;
    int shift;
    int reject;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];

  // Reference model state: modes as 0=P 1=N 2=R 3=D
  int m_mode;
  int m_gear;
  int m_since;
  int m_shift;
  int m_reject;

  gear_selector_fsm_if #(.NUM_GEARS(NG), .SPEED_W(SW)) bus ();

  gear_selector_fsm #(
    .NUM_GEARS(NG), .SPEED_W(SW), .SHIFT_STEP(STEP), .HYST(HY), .DWELL_CYCLES(DWELL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_gear = 0; m_since = 0; m_shift = 0; m_reject = 0;
  endtask

  // One clock of the selector rules, counting cycles since the last D entry or shift
  task automatic model_step(input bit sp, input bit sn, input bit sr, input bit sd,
                            input int spd);
    int  req;
    bit  grant;
    bit  changed;
    m_shift = 0; m_reject = 0; changed = 0;
    req = sp ? 0 : sn ? 1 : sr ? 2 : sd ? 3 : -1;
    if (req >= 0 && req != m_mode) begin
      if (req == 1)      grant = 1;
      else if (req == 3) grant = (m_mode != 2) || (spd == 0);
      else               grant = (spd == 0);
      if (grant) begin
        m_mode  = req;
        m_gear  = (req == 3) ? 1 : 0;
        m_since = 0;
        changed = 1;
      end else begin
        m_reject = 1;
      end
    end
    if (!changed && m_mode == 3) begin
      if (m_since >= DWELL - 1 && m_gear > 1 && spd + HY < (m_gear - 1) * STEP) begin
        m_gear--; m_shift = 1;
      end else if (m_since >= DWELL - 1 && m_gear < NG && spd >= m_gear * STEP) begin
        m_gear++; m_shift = 1;
      end
      m_since = m_shift ? 0 : m_since + 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.mode   = m_mode;
    e.p      = (m_mode == 0);
    e.n      = (m_mode == 1);
    e.r      = (m_mode == 2);
    e.gear   = m_gear;
    e.oh     = (m_gear == 0) ? 0 : (1 << (m_gear - 1));
    e.shift  = m_shift;
    e.reject = m_reject;
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected response
  task automatic cycle(input bit sp, input bit sn, input bit sr, input bit sd, input int spd);
    @(negedge clk);
    reset     = 1'b0;
    bus.sel_p = sp;
    bus.sel_n = sn;
    bus.sel_r = sr;
    bus.sel_d = sd;
    bus.speed = SW'(spd);
    model_step(sp, sn, sr, sd, spd);
    exp_q.push_back(model_out());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mode"},   int'(bus.mode_o), 0);
    chk({tag, "_p"},      int'(bus.p_o), 1);
    chk({tag, "_n"},      int'(bus.n_o), 0);
    chk({tag, "_r"},      int'(bus.r_o), 0);
    chk({tag, "_gear"},   int'(bus.gear_o), 0);
    chk({tag, "_oh"},     int'(bus.gear_oh_o), 0);
    chk({tag, "_shift"},  int'(bus.shift_o), 0);
    chk({tag, "_reject"}, int'(bus.reject_o), 0);
  endtask

  // Asynchronous reset mid-operation: outputs must clear before any clock edge
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs(tag);
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  // Monitor: outputs are presented every cycle; compare just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mode",    int'(bus.mode_o),    e.mode);
        chk("p_o",     int'(bus.p_o),       e.p);
        chk("n_o",     int'(bus.n_o),       e.n);
        chk("r_o",     int'(bus.r_o),       e.r);
        chk("gear",    int'(bus.gear_o),    e.gear);
        chk("gear_oh", int'(bus.gear_oh_o), e.oh);
        chk("shift",   int'(bus.shift_o),   e.shift);
        chk("reject",  int'(bus.reject_o),  e.reject);
      end
    end
  end

  initial begin
    int spd;
    int lev;
    int hold;
    clk = 1'b0; reset = 1'b0;
    n_checks = 0; n_errors = 0;
    bus.sel_p = 0; bus.sel_n = 0; bus.sel_r = 0; bus.sel_d = 0; bus.speed = '0;
`ifdef GEAR_SELECTOR_KICKDOWN_EN
    bus.kickdown = 1'b0;
`endif
    #1 reset = 1'b1;
    #3 check_reset_outputs("por");
    model_reset();

    // Enter D at standstill, then climb through all gears and saturate
    cycle(0, 0, 0, 1, 0);
    repeat (20) cycle(0, 0, 0, 0, 20);
    repeat (60) cycle(0, 0, 0, 0, 200);
    // Hysteresis: 37 drops 4->3 but holds in 3; 35 drops to 2
    repeat (40) cycle(0, 0, 0, 0, 37);
    repeat (20) cycle(0, 0, 0, 0, 35);
    // Interlock: R denied while moving, N granted, P at standstill
    repeat (4) cycle(0, 0, 1, 0, 50);
    cycle(0, 1, 0, 0, 50);
    cycle(1, 0, 0, 0, 0);
    // Priority: P and D together from N resolves to P
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    // R at standstill, D from R blocked while moving, then granted at zero
    cycle(0, 0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 1, 5);
    cycle(0, 0, 0, 1, 0);
    // Reach gear 3 then reset asynchronously
    repeat (40) cycle(0, 0, 0, 0, 200);
    async_reset("mid_gear");

    // Randomized levers and a wandering speed
    spd = 0; lev = 0; hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0)      spd = 0;
      else if ($urandom_range(0, 99) == 0) spd = $urandom_range(0, 255);
      else begin
        spd = spd + $urandom_range(0, 6) - 3;
        if (spd < 0) spd = 0;
        if (spd > 255) spd = 255;
      end
      if (hold > 0) hold--;
      else if ($urandom_range(0, 39) == 0) begin
        lev  = $urandom_range(0, 15);
        hold = $urandom_range(0, 3);
      end else lev = 0;
      if ($urandom_range(0, 799) == 0) async_reset("rand_reset");
      else cycle(lev[3], lev[2], lev[1], lev[0], spd);
    end

    repeat (3) @(posedge clk);
    #2 chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gear_selector_fsm.md
Name: gear_selector_fsm

Overview:
- Parametrised automatic-transmission selector FSM that generalises the 4-speed P/N/R/D controller.
- Holds the P/N/R/D mode from one-hot-ish selector inputs with priority P>N>R>D.
- Adds a speed interlock on P/R/D entry and speed-driven up/down shifting across NUM_GEARS gears.
- Shifts use hysteresis and a minimum dwell time between shifts; instantiated between the selector decode and the gear-indicator/actuator logic.

Parameters:
- NUM_GEARS, 6: forward gears in D; legal range 2..15.
- SPEED_W, 8: width of the unsigned speed input.
- SHIFT_STEP, 20: speed span per gear; upshift from gear g when speed >= g*SHIFT_STEP.
- HYST, 4: downshift hysteresis; must satisfy 0 < HYST < SHIFT_STEP.
- DWELL_CYCLES, 16: minimum cycles between consecutive shifts; >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- sel_p, sel_n, sel_r, sel_d  in  1 each  lever request lines (level)
- speed  in  SPEED_W  vehicle speed, unsigned, sampled every cycle
- mode_o  out  2  current mode; P=00, N=01, R=10, D=11
- p_o, n_o, r_o  out  1 each  mode indicators (exactly one of p_o/n_o/r_o/D-active is high)
- gear_o  out  GEAR_W=$clog2(NUM_GEARS+1)  current gear; 0 outside D, 1..NUM_GEARS in D
- gear_oh_o  out  NUM_GEARS  one-hot of gear_o; all zero outside D
- shift_o  out  1  one-cycle pulse on the cycle gear_o changes while staying in D
- reject_o  out  1  one-cycle pulse when a mode request is denied by the interlock

Behaviour:
- Reset (async): mode=P, gear=0, dwell counter=0, shift_o=0, reject_o=0. Outputs: p_o=1, all others 0.
- All outputs are registered. A selector or speed change is reflected in the outputs on the next clk edge (1-cycle latency).
- Request resolution, per cycle: req = P if sel_p, else N if sel_n, else R if sel_r, else D if sel_d, else none.
  - No request holds the current mode.
  - A request equal to the current mode is a no-op (no reject).
- Interlock:
  - N is always granted.
  - P or R from any other mode is granted only if speed==0.
  - D from R is granted only if speed==0. D from P or N is always granted.
  - A denied request keeps the mode and pulses reject_o for one cycle. reject_o re-pulses every cycle the denied request persists.
- Entering D: gear=1 and dwell counter loaded with DWELL_CYCLES-1; shift_o does not pulse on entry.
- Leaving D: gear=0; the dwell counter is cleared.
- In D, the dwell counter decrements to 0 and saturates. Shifts are evaluated only when the counter is 0.
  - Upshift: gear<NUM_GEARS and speed >= gear*SHIFT_STEP.
  - Downshift: gear>1 and speed+HYST < (gear-1)*SHIFT_STEP.
  - At most one gear step per shift event. A shift reloads the counter with DWELL_CYCLES-1 and pulses shift_o.
  - With HYST < SHIFT_STEP, up and down conditions are mutually exclusive. If both were somehow true, upshift is suppressed and downshift wins.
- Threshold arithmetic is done at SPEED_W+GEAR_W+1 bits with no truncation. Thresholds above the speed range are simply never reached.
- Boundaries:
  - Gear saturates at 1 and NUM_GEARS, with no wrap.
  - The dwell counter never underflows.
  - Asserting reset mid-shift or mid-dwell returns immediately to the reset state.
- A mode change and a gear shift in the same cycle: the mode change wins and no shift is evaluated.

Optional Feature:
- GEAR_SELECTOR_KICKDOWN_EN defined:
  - Adds input port kickdown (1 bit).
  - In D with gear>1, kickdown=1 forces a one-gear downshift regardless of the dwell counter and speed, reloads dwell, and pulses shift_o.
  - It ignores further kickdown until the dwell expires.
- Not defined: port absent and no kickdown logic.

Decomposition:
- Package gear_pkg holds:
  - mode enum/localparams (MODE_P/N/R/D = 00/01/10/11),
  - a GEAR_W computation function,
  - the request-priority encoding.
- Sub-module shift_dwell_timer (load, decrement, saturate, zero flag; width $clog2(DWELL_CYCLES)+1) is natural.
- Threshold compare stays in the top module.

Test Plan:
All scenarios use NUM_GEARS=4, SHIFT_STEP=20, HYST=4, DWELL_CYCLES=16.
- Reset, then sel_d=1 at speed=0 -> next cycle mode_o=11, gear_o=1, gear_oh_o=0001, shift_o=0.
- In D, ramp speed to 20 at cycle 0 -> gear stays 1 until dwell expires (cycle 15), then gear_o=2 with a 1-cycle shift_o. Speed 200 held -> gears 3 and 4 each follow after 16 more cycles, then saturate at 4.
- Gear 3, speed 37 (37+4 >= 40) -> no downshift. Speed 35 (35+4 < 40) -> gear_o=2 after dwell.
- In D at speed=50, assert sel_r -> reject_o pulses each cycle and mode stays D. With sel_n -> mode N, gear_o=0. Then sel_p with speed 0 -> mode P, p_o=1.
- sel_p and sel_d asserted together in N at speed 0 -> P wins. Assert reset while in gear 3 -> mode P and gear 0 asynchronously (before the next edge).
- With GEAR_SELECTOR_KICKDOWN_EN: gear 4, 2 cycles after a shift, kickdown=1 -> gear_o=3 next cycle. kickdown held -> no further shift for 16 cycles.
